// File: rtl/ika_timinggen_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ika_timinggen_param                                          |
// | Description : Parametrised slot-timing generator. Derives phi1 and its     |
// |               clock enables from the phiM enable, synchronises IC_n into   |
// |               the core master reset, runs a 2^CNTR_W slot counter and      |
// |               produces NTAP runtime-programmable decode strobes plus       |
// |               delayed SH1/SH2 strobes.                                     |
// | Options     : IKA_TIMINGGEN_FREEZE_EN adds i_FREEZE, which holds the       |
// |               counter, taps, SH pipeline and tap-apply on NCEN.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ika_timinggen_param #(
  parameter int CNTR_W   = 5,
  parameter int NTAP     = 8,
  parameter int SH_DELAY = 5,
  localparam int SEL_W   = (NTAP > 1) ? $clog2(NTAP) : 1
) (
  input  logic              i_EMUCLK,
  input  logic              i_RST,
  input  logic              i_IC_n,
  input  logic              i_phiM_PCEN_n,
`ifdef IKA_TIMINGGEN_FREEZE_EN
  input  logic              i_FREEZE,
`endif
  output logic              o_MRST_n,
  output logic              o_phi1,
  output logic              o_phi1_PCEN_n,
  output logic              o_phi1_NCEN_n,
  output logic [CNTR_W-1:0] o_CNTR,
  input  logic              i_TAP_WR,
  input  logic [SEL_W-1:0]  i_TAP_SEL,
  input  logic [CNTR_W-1:0] i_TAP_VAL,
  input  logic [CNTR_W-1:0] i_TAP_MASK,
  output logic              o_TAP_PEND,
  output logic [NTAP-1:0]   o_TAP,
  output logic              o_SH1,
  output logic              o_SH2
);

  localparam logic [CNTR_W-1:0] CNTR_MAX = '1;

  // phiM enable, IC synchroniser and phi1 generator state
  logic       phim_en;
  logic [1:0] ic_sync;     // [0] = newest sample (stage0), [1] = stage1
  logic       phi1_init;
  logic       phi1p;
  logic       phi1n;
  logic       ncen;
  logic       hold;
  logic       step;

  // tap storage: active set and single-entry shadow
  logic [CNTR_W-1:0] tap_val  [NTAP];
  logic [CNTR_W-1:0] tap_mask [NTAP];
  logic [SEL_W-1:0]  shadow_sel;
  logic [CNTR_W-1:0] shadow_val;
  logic [CNTR_W-1:0] shadow_mask;
  logic              apply;
  logic [NTAP-1:0]   tap_hit;

  // SH pipelines
  logic [SH_DELAY-1:0] sh1_sr;
  logic [SH_DELAY-1:0] sh2_sr;
  logic                sh1_src;
  logic                sh2_src;

  assign phim_en = ~i_phiM_PCEN_n;

`ifdef IKA_TIMINGGEN_FREEZE_EN
  assign hold = i_FREEZE;
`else
  assign hold = 1'b0;
`endif

  // IC_n sampling, IC falling-edge detect and phi1 phase generation on phiM
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      ic_sync   <= 2'b00;
      phi1_init <= 1'b1;
      phi1p     <= 1'b1;
      phi1n     <= 1'b0;
    end else if (phim_en) begin
      ic_sync   <= {ic_sync[0], i_IC_n};
      phi1_init <= ~ic_sync[0] & ic_sync[1];
      if (phi1_init) begin
        phi1p <= 1'b1;
        phi1n <= 1'b0;
      end else begin
        phi1p <= ~phi1p;
        phi1n <= ~phi1n;
      end
    end
  end

  // phi1_init suppresses the negative enable so the restart phase is clean
  assign o_phi1        = phi1p;
  assign o_phi1_PCEN_n = phi1p | i_phiM_PCEN_n;
  assign o_phi1_NCEN_n = phi1n | i_phiM_PCEN_n | phi1_init;
  assign ncen          = ~o_phi1_NCEN_n;
  assign step          = ncen & ~hold;

  // Master reset and slot counter; reset clears the counter even when frozen
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      o_MRST_n <= 1'b0;
      o_CNTR   <= '0;
    end else if (ncen) begin
      o_MRST_n <= ic_sync[0];
      if (!o_MRST_n) begin
        o_CNTR <= '0;
      end else if (!hold) begin
        o_CNTR <= o_CNTR + 1'b1;
      end
    end
  end

  // Per-tap masked compare against the current slot
  always_comb begin
    tap_hit = '0;
    for (int k = 0; k < NTAP; k++) begin
      tap_hit[k] = ((o_CNTR ^ tap_val[k]) & tap_mask[k]) == '0;
    end
  end

  // Apply the shadow only at a frame boundary (or while in reset) so a tap
  // never changes mid-frame
  assign apply = step & o_TAP_PEND & ((o_CNTR == CNTR_MAX) | ~o_MRST_n);

  // Shadow capture; writes are dropped while an earlier one is still pending
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      o_TAP_PEND  <= 1'b0;
      shadow_sel  <= '0;
      shadow_val  <= '0;
      shadow_mask <= '0;
    end else if (!o_TAP_PEND) begin
      if (i_TAP_WR) begin
        o_TAP_PEND  <= 1'b1;
        shadow_sel  <= i_TAP_SEL;
        shadow_val  <= i_TAP_VAL;
        shadow_mask <= i_TAP_MASK;
      end
    end else if (apply) begin
      o_TAP_PEND <= 1'b0;
    end
  end

  // Active tap table; an out-of-range select matches no entry and is dropped
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      for (int k = 0; k < NTAP; k++) begin
        tap_val[k]  <= '0;
        tap_mask[k] <= '1;
      end
    end else if (apply) begin
      for (int k = 0; k < NTAP; k++) begin
        if (shadow_sel == SEL_W'(k)) begin
          tap_val[k]  <= shadow_val;
          tap_mask[k] <= shadow_mask;
        end
      end
    end
  end

  // Registered decode strobes
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      o_TAP <= '0;
    end else if (step) begin
      o_TAP <= tap_hit;
    end
  end

  assign sh1_src = (o_CNTR[CNTR_W-1 -: 2] == 2'b11);
  assign sh2_src = (o_CNTR[CNTR_W-1 -: 2] == 2'b01);

  // SH delay lines plus output stage gated by master reset
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      sh1_sr <= '0;
      sh2_sr <= '0;
      o_SH1  <= 1'b0;
      o_SH2  <= 1'b0;
    end else if (step) begin
      sh1_sr[0] <= sh1_src;
      sh2_sr[0] <= sh2_src;
      for (int i = 1; i < SH_DELAY; i++) begin
        sh1_sr[i] <= sh1_sr[i-1];
        sh2_sr[i] <= sh2_sr[i-1];
      end
      o_SH1 <= sh1_sr[SH_DELAY-1] & o_MRST_n;
      o_SH2 <= sh2_sr[SH_DELAY-1] & o_MRST_n;
    end
  end

endmodule
`default_nettype wire
